// File: rtl/mem_ctrl_param.sv
// mem_ctrl_param: single-bank SDRAM-style memory controller.
// Accepts one host read/write at a time, opens the addressed row (precharging
// a different open row first), issues RD/WR, then serialises write data onto
// the DQ lanes LSB lane first, or deserialises read data CL cycles later.
// PAGE_POLICY=0 leaves the row open; PAGE_POLICY=1 auto-precharges after each
// access.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_n, RDnWR        active-low request strobe, 1=read / 0=write
//   Addr_in             {row[RA_W], column[CA_W]}
//   Data_in_vld/Data_in write data (must be valid for a write to be accepted)
//   cmd_rdy             controller idle and able to accept a request
//   Data_out            last completed read word, data_out_vld strobes it
//   command, RA, CA     memory command bus (NOP/ACT/RD/WR/PRE), row, column
//   cs_n                active-low chip select, low whenever command != NOP
//   dq_out/dq_oe/dq_in  split memory data lanes
// All outputs are registered.
module mem_ctrl_param #(
  parameter int DATA_W      = 32,
  parameter int DQ_W        = 1,
  parameter int RA_W        = 4,
  parameter int CA_W        = 12,
  parameter int TRCD        = 2,
  parameter int TRP         = 2,
  parameter int CL          = 2,
  parameter int PAGE_POLICY = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_n,
  input  logic                   RDnWR,
  input  logic [RA_W+CA_W-1:0]   Addr_in,
  input  logic                   Data_in_vld,
  input  logic [DATA_W-1:0]      Data_in,
  output logic                   cmd_rdy,
  output logic [DATA_W-1:0]      Data_out,
  output logic                   data_out_vld,
  output logic [2:0]             command,
  output logic [RA_W-1:0]        RA,
  output logic [CA_W-1:0]        CA,
  output logic                   cs_n,
  output logic [DQ_W-1:0]        dq_out,
  output logic                   dq_oe,
  input  logic [DQ_W-1:0]        dq_in
);

  localparam int ADDR_W = RA_W + CA_W;
  localparam int BEATS  = DATA_W / DQ_W;
  localparam logic [DATA_W-1:0] LANE_MASK = DATA_W'({DQ_W{1'b1}});

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_TRP_WAIT, S_ACT, S_TRCD_WAIT,
    S_RW_CMD, S_WR_XFER, S_RD_LAT, S_RD_XFER, S_AUTO_PRE
  } state_t;

  typedef enum logic [2:0] {
    CMD_NOP = 3'b000,
    CMD_ACT = 3'b001,
    CMD_RD  = 3'b010,
    CMD_WR  = 3'b011,
    CMD_PRE = 3'b100
  } cmd_t;

  state_t              state_q, state_d, done_state;
  logic [31:0]         cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic                open_q, open_d;
  logic [RA_W-1:0]     orow_q, orow_d;
  logic                closing_q, closing_d;
  cmd_t                cmd_q, cmd_d;
  logic                csn_q, csn_d;
  logic [RA_W-1:0]     ra_q, ra_d;
  logic [CA_W-1:0]     ca_q, ca_d;
  logic                oe_q, oe_d;
  logic [DQ_W-1:0]     dqo_q, dqo_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                vld_q, vld_d;
  logic                rdy_q, rdy_d;
  logic                accept;
  logic [31:0]         sh;

  assign done_state = (PAGE_POLICY != 0) ? S_AUTO_PRE : S_IDLE;
  assign accept     = ~cmd_n & rdy_q & (RDnWR | Data_in_vld);
  assign sh         = cnt_q * DQ_W;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    closing_d = closing_q;
    dout_d    = dout_q;
    vld_d     = 1'b0;

    // Multi-cycle states enter with cnt=0 and leave when cnt hits length-1.
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rd_d      = RDnWR;
          addr_d    = Addr_in;
          wdata_d   = Data_in;
          closing_d = 1'b0;
          cnt_d     = '0;
          if (open_q && orow_q == Addr_in[ADDR_W-1 -: RA_W]) state_d = S_RW_CMD;
          else if (open_q)                                    state_d = S_PRE;
          else                                                state_d = S_ACT;
        end
      end
      S_PRE: begin
        cnt_d   = '0;
        state_d = (TRP > 1) ? S_TRP_WAIT : S_ACT;
      end
      S_TRP_WAIT: begin
        if (cnt_q == TRP - 2) begin
          cnt_d   = '0;
          state_d = closing_q ? S_IDLE : S_ACT;
        end
      end
      S_ACT: begin
        cnt_d   = '0;
        state_d = (TRCD > 1) ? S_TRCD_WAIT : S_RW_CMD;
      end
      S_TRCD_WAIT: begin
        if (cnt_q == TRCD - 2) state_d = S_RW_CMD;
      end
      S_RW_CMD: begin
        cnt_d   = '0;
        state_d = rd_q ? S_RD_LAT : S_WR_XFER;
      end
      S_WR_XFER: begin
        if (cnt_q == BEATS - 1) state_d = done_state;
      end
      S_RD_LAT: begin
        if (cnt_q == CL - 1) begin
          cnt_d   = '0;
          state_d = S_RD_XFER;
        end
      end
      S_RD_XFER: begin
        rbuf_d = (rbuf_q & ~(LANE_MASK << sh)) | (DATA_W'(dq_in) << sh);
        if (cnt_q == BEATS - 1) begin
          dout_d  = rbuf_d;
          vld_d   = 1'b1;
          state_d = done_state;
        end
      end
      S_AUTO_PRE: begin
        cnt_d     = '0;
        closing_d = 1'b1;
        state_d   = (TRP > 1) ? S_TRP_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered: each is the value for the state being entered.
  always_comb begin
    open_d = open_q;
    orow_d = orow_q;
    ra_d   = ra_q;
    ca_d   = ca_q;
    cmd_d  = CMD_NOP;
    case (state_d)
      S_ACT: begin
        cmd_d  = CMD_ACT;
        ra_d   = addr_d[ADDR_W-1 -: RA_W];
        open_d = 1'b1;
        orow_d = addr_d[ADDR_W-1 -: RA_W];
      end
      S_PRE, S_AUTO_PRE: begin
        cmd_d  = CMD_PRE;
        open_d = 1'b0;
        orow_d = '0;
      end
      S_RW_CMD: begin
        cmd_d = rd_d ? CMD_RD : CMD_WR;
        ca_d  = addr_d[CA_W-1:0];
      end
      default: cmd_d = CMD_NOP;
    endcase
    csn_d = (cmd_d == CMD_NOP);
    oe_d  = (state_d == S_WR_XFER);
    dqo_d = oe_d ? DQ_W'(wdata_d >> (cnt_d * DQ_W)) : '0;
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      open_q    <= 1'b0;
      orow_q    <= '0;
      closing_q <= 1'b0;
      cmd_q     <= CMD_NOP;
      csn_q     <= 1'b1;
      ra_q      <= '0;
      ca_q      <= '0;
      oe_q      <= 1'b0;
      dqo_q     <= '0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      open_q    <= open_d;
      orow_q    <= orow_d;
      closing_q <= closing_d;
      cmd_q     <= cmd_d;
      csn_q     <= csn_d;
      ra_q      <= ra_d;
      ca_q      <= ca_d;
      oe_q      <= oe_d;
      dqo_q     <= dqo_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      rdy_q     <= rdy_d;
    end
  end

  assign command      = cmd_q;
  assign cs_n         = csn_q;
  assign RA           = ra_q;
  assign CA           = ca_q;
  assign dq_oe        = oe_q;
  assign dq_out       = dqo_q;
  assign Data_out     = dout_q;
  assign data_out_vld = vld_q;
  assign cmd_rdy      = rdy_q;

endmodule

// File: tb/tb_mem_ctrl_param.sv
// Directed bench for mem_ctrl_param (DATA_W=32, DQ_W=4, TRCD=TRP=CL=2).
// u0 runs open-page, u1 runs closed-page; sel routes the request strobe and
// the observed outputs to one of them.
module tb_mem_ctrl_param;
  localparam int DW = 32, QW = 4, RW = 4, CW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic cmd_n_drv = 1'b1;
  logic cmd_n0, cmd_n1;
  logic RDnWR = 1'b0;
  logic [RW+CW-1:0] Addr_in = '0;
  logic Data_in_vld = 1'b0;
  logic [DW-1:0] Data_in = '0;
  logic [QW-1:0] dq_in = '0;

  logic [2:0] cmd0, cmd1, o_cmd;
  logic [RW-1:0] ra0, ra1, o_ra;
  logic [CW-1:0] ca0, ca1, o_ca;
  logic csn0, csn1, o_csn, oe0, oe1, o_oe, vld0, vld1, o_vld, rdy0, rdy1, o_rdy;
  logic [QW-1:0] dqo0, dqo1, o_dqo;
  logic [DW-1:0] dout0, dout1, o_dout;

  assign cmd_n0 = sel ? 1'b1 : cmd_n_drv;
  assign cmd_n1 = sel ? cmd_n_drv : 1'b1;
  assign o_cmd  = sel ? cmd1 : cmd0;
  assign o_ra   = sel ? ra1 : ra0;
  assign o_ca   = sel ? ca1 : ca0;
  assign o_csn  = sel ? csn1 : csn0;
  assign o_oe   = sel ? oe1 : oe0;
  assign o_vld  = sel ? vld1 : vld0;
  assign o_rdy  = sel ? rdy1 : rdy0;
  assign o_dqo  = sel ? dqo1 : dqo0;
  assign o_dout = sel ? dout1 : dout0;

  mem_ctrl_param #(.DATA_W(DW), .DQ_W(QW), .RA_W(RW), .CA_W(CW), .TRCD(2), .TRP(2),
                   .CL(2), .PAGE_POLICY(0)) u0 (
    .clk(clk), .rst(rst), .cmd_n(cmd_n0), .RDnWR(RDnWR), .Addr_in(Addr_in),
    .Data_in_vld(Data_in_vld), .Data_in(Data_in), .cmd_rdy(rdy0), .Data_out(dout0),
    .data_out_vld(vld0), .command(cmd0), .RA(ra0), .CA(ca0), .cs_n(csn0),
    .dq_out(dqo0), .dq_oe(oe0), .dq_in(dq_in));

  mem_ctrl_param #(.DATA_W(DW), .DQ_W(QW), .RA_W(RW), .CA_W(CW), .TRCD(2), .TRP(2),
                   .CL(2), .PAGE_POLICY(1)) u1 (
    .clk(clk), .rst(rst), .cmd_n(cmd_n1), .RDnWR(RDnWR), .Addr_in(Addr_in),
    .Data_in_vld(Data_in_vld), .Data_in(Data_in), .cmd_rdy(rdy1), .Data_out(dout1),
    .data_out_vld(vld1), .command(cmd1), .RA(ra1), .CA(ca1), .cs_n(csn1),
    .dq_out(dqo1), .dq_oe(oe1), .dq_in(dq_in));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic hammer = 1'b0;

  logic [2:0]    e_cmd [0:31];
  logic          e_oe  [0:31];
  logic [3:0]    e_dq  [0:31];
  logic          e_rdy [0:31];
  logic          e_vld [0:31];
  logic [RW-1:0] ra_log [0:31];
  logic [CW-1:0] ca_log [0:31];
  logic [DW-1:0] dout_log [0:31];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 32; i++) begin
      e_cmd[i] = 3'b000; e_oe[i] = 1'b0; e_dq[i] = 4'h0; e_rdy[i] = 1'b0; e_vld[i] = 1'b0;
    end
  endtask

  task automatic exp_write_beats(input logic [DW-1:0] wd, input int first);
    logic [DW-1:0] w;
    w = wd;
    for (int i = 0; i < 8; i++) begin
      e_oe[first + i] = 1'b1;
      e_dq[first + i] = w[3:0];
      w = w >> 4;
    end
  endtask

  task automatic request(input logic rd, input logic [15:0] a, input logic [31:0] d, input logic dv);
    RDnWR = rd; Addr_in = a; Data_in = d; Data_in_vld = dv; cmd_n_drv = 1'b0;
  endtask

  // Runs cycles 1..n after an acceptance cycle; drives read data base.. in
  // cycles dstart..dstart+7 (0xF elsewhere) and checks every cycle.
  task automatic run(input string tag, input int n, input int dstart, input logic [3:0] base);
    for (int c = 1; c <= n; c++) begin
      step();
      cmd_n_drv = (hammer && c < n) ? 1'b0 : 1'b1;
      if (hammer) begin
        RDnWR = 1'b0; Addr_in = 16'h9ABC; Data_in_vld = 1'b1; Data_in = 32'h5A5A5A5A;
      end else begin
        RDnWR = ~RDnWR; Addr_in = 16'hEEEE; Data_in = 32'hDEADBEEF;
      end
      dq_in = (c >= dstart && c < dstart + 8) ? 4'(int'(base) + c - dstart) : 4'hF;
      chk($sformatf("%s.cmd@%0d", tag, c), 64'(o_cmd), 64'(e_cmd[c]));
      chk($sformatf("%s.cs_n@%0d", tag, c), 64'(o_csn), 64'(e_cmd[c] == 3'b000));
      chk($sformatf("%s.oe@%0d", tag, c), 64'(o_oe), 64'(e_oe[c]));
      chk($sformatf("%s.dq@%0d", tag, c), 64'(o_dqo), 64'(e_dq[c]));
      chk($sformatf("%s.rdy@%0d", tag, c), 64'(o_rdy), 64'(e_rdy[c]));
      chk($sformatf("%s.vld@%0d", tag, c), 64'(o_vld), 64'(e_vld[c]));
      ra_log[c] = o_ra; ca_log[c] = o_ca; dout_log[c] = o_dout;
    end
  endtask

  initial begin
    bit done;
    // Reset state
    repeat (3) step();
    chk("rst.cmd", 64'(cmd0), 64'(3'b000));
    chk("rst.cs_n", 64'(csn0), 64'd1);
    chk("rst.RA", 64'(ra0), 64'd0);
    chk("rst.CA", 64'(ca0), 64'd0);
    chk("rst.oe", 64'(oe0), 64'd0);
    chk("rst.dq", 64'(dqo0), 64'd0);
    chk("rst.dout", 64'(dout0), 64'd0);
    chk("rst.vld", 64'(vld0), 64'd0);
    chk("rst.rdy", 64'(rdy0), 64'd0);
    chk("rst.rdy_u1", 64'(rdy1), 64'd0);
    rst = 1'b0;
    step();
    chk("rel.rdy", 64'(rdy0), 64'd1);
    chk("rel.rdy_u1", 64'(rdy1), 64'd1);

    // Write after reset: ACT 1, WR 3, beats 4-11, ready 12
    request(1'b0, 16'h30A5, 32'h87654321, 1'b1);
    clear_exp();
    e_cmd[1] = 3'b001; e_cmd[3] = 3'b011; e_rdy[12] = 1'b1;
    exp_write_beats(32'h87654321, 4);
    run("wr", 12, 99, 4'h0);
    chk("wr.RA@1", 64'(ra_log[1]), 64'h3);
    chk("wr.CA@3", 64'(ca_log[3]), 64'h0A5);
    chk("wr.RAhold@12", 64'(ra_log[12]), 64'h3);

    // Row-hit read: RD 1, sample 4-11, data_out_vld 12
    request(1'b1, 16'h30A5, 32'h0, 1'b0);
    clear_exp();
    e_cmd[1] = 3'b010; e_rdy[12] = 1'b1; e_vld[12] = 1'b1;
    run("rdhit", 12, 4, 4'h1);
    chk("rdhit.CA@1", 64'(ca_log[1]), 64'h0A5);
    chk("rdhit.douthold@11", 64'(dout_log[11]), 64'h0);
    chk("rdhit.dout@12", 64'(dout_log[12]), 64'h87654321);

    // Row-miss read: PRE 1, ACT 3, RD 5, sample 8-15, vld 16
    request(1'b1, 16'h5001, 32'h0, 1'b0);
    clear_exp();
    e_cmd[1] = 3'b100; e_cmd[3] = 3'b001; e_cmd[5] = 3'b010;
    e_rdy[16] = 1'b1; e_vld[16] = 1'b1;
    run("rdmiss", 16, 8, 4'h8);
    chk("rdmiss.RA@3", 64'(ra_log[3]), 64'h5);
    chk("rdmiss.CA@5", 64'(ca_log[5]), 64'h001);
    chk("rdmiss.douthold@15", 64'(dout_log[15]), 64'h87654321);
    chk("rdmiss.dout@16", 64'(dout_log[16]), 64'hFEDCBA98);

    // Write without Data_in_vld is ignored
    request(1'b0, 16'h5001, 32'h11111111, 1'b0);
    clear_exp();
    e_rdy[1] = 1'b1; e_rdy[2] = 1'b1; e_rdy[3] = 1'b1;
    run("novld", 3, 99, 4'h0);

    // Row-hit read with requests held while busy
    request(1'b1, 16'h5001, 32'h0, 1'b0);
    clear_exp();
    e_cmd[1] = 3'b010; e_rdy[12] = 1'b1; e_vld[12] = 1'b1;
    hammer = 1'b1;
    run("busy", 12, 4, 4'h3);
    hammer = 1'b0;
    chk("busy.CA@1", 64'(ca_log[1]), 64'h001);
    step();
    chk("busy.cmd@13", 64'(cmd0), 64'(3'b000));
    chk("busy.rdy@13", 64'(rdy0), 64'd1);
    chk("busy.dout@13", 64'(dout0), 64'hA9876543);

    // Reset during read beat 4 (cycle 7)
    request(1'b1, 16'h5001, 32'h0, 1'b0);
    step();
    cmd_n_drv = 1'b1;
    chk("abort.cmd@1", 64'(cmd0), 64'(3'b010));
    for (int c = 2; c <= 7; c++) begin
      step();
      dq_in = 4'(c);
    end
    rst = 1'b1;
    step();
    chk("abort.cmd@8", 64'(cmd0), 64'(3'b000));
    chk("abort.cs_n@8", 64'(csn0), 64'd1);
    chk("abort.vld@8", 64'(vld0), 64'd0);
    chk("abort.oe@8", 64'(oe0), 64'd0);
    chk("abort.rdy@8", 64'(rdy0), 64'd0);
    rst = 1'b0;
    step();
    chk("abort.rdy@9", 64'(rdy0), 64'd1);
    chk("abort.vld@9", 64'(vld0), 64'd0);
    chk("abort.dout@9", 64'(dout0), 64'd0);

    // After reset the row is closed: ACT 1, RD 3, sample 6-13, vld 14
    request(1'b1, 16'h5001, 32'h0, 1'b0);
    clear_exp();
    e_cmd[1] = 3'b001; e_cmd[3] = 3'b010; e_rdy[14] = 1'b1; e_vld[14] = 1'b1;
    run("reopen", 14, 6, 4'h0);
    chk("reopen.RA@1", 64'(ra_log[1]), 64'h5);
    chk("reopen.dout@14", 64'(dout_log[14]), 64'h76543210);

    // Closed-page instance: ACT 1, WR 3, beats 4-11, PRE 12, ready 14
    sel = 1'b1;
    request(1'b0, 16'h1000, 32'hCAFEF00D, 1'b1);
    clear_exp();
    e_cmd[1] = 3'b001; e_cmd[3] = 3'b011; e_cmd[12] = 3'b100; e_rdy[14] = 1'b1;
    exp_write_beats(32'hCAFEF00D, 4);
    run("cp.wr", 14, 99, 4'h0);
    chk("cp.RA@1", 64'(ra_log[1]), 64'h1);
    chk("cp.CA@3", 64'(ca_log[3]), 64'h000);

    // Same row again must reopen with ACT first
    request(1'b1, 16'h1000, 32'h0, 1'b0);
    clear_exp();
    e_cmd[1] = 3'b001; e_cmd[3] = 3'b010;
    run("cp.rd", 3, 6, 4'h2);
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      done = rdy1;
    end
    chk("cp.drain", 64'(done), 64'd1);
    sel = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
